// File: rtl/msu_data_fetch.sv
`default_nettype none
// ============================================================================
// Module   : msu_data_fetch
// Brief    : MSU-1 data-port prefetcher with a 16-bit word fetch engine and a byte ring buffer.
// Revision : 1.0  initial release
// ============================================================================
module msu_data_fetch #(
    parameter int DEPTH = 16
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] msu_data_addr,
    input  logic        msu_data_seek,
    input  logic        msu_data_req,
    output logic [7:0]  msu_data_in,
    output logic        msu_status_data_busy,
    output logic        mem_rd,
    output logic [30:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_dout
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_REFILL_MAX = c_CW'(DEPTH - 2);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_REQ   = 2'd1;
    localparam logic [1:0] c_S_STALE = 2'd2;

    logic [7:0]      buf_q [DEPTH];
    logic [1:0]      state_q, state_d;
    logic [c_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [c_CW-1:0] count_q, count_d;
    logic [30:0]     fetch_q, fetch_d, mem_addr_q, mem_addr_d;
    logic            skip_q, skip_d, armed_q, armed_d, pend_q, pend_d, busy_q, busy_d;
    logic [7:0]      data_q, data_d;

    logic            w_ack_ok, w_req_v, w_wr1_en, w_space_ok;
    logic [1:0]      w_n_in, w_npop, w_pops;
    logic [c_CW-1:0] w_avail;
    logic [7:0]      w_wr0_data, w_rd_byte;

    assign w_ack_ok   = (state_q == c_S_REQ) && mem_ack && !msu_data_seek;
    assign w_req_v    = msu_data_req && armed_q && !msu_data_seek;
    assign w_n_in     = w_ack_ok ? (skip_q ? 2'd1 : 2'd2) : 2'd0;
    assign w_wr1_en   = w_ack_ok && !skip_q;
    assign w_wr0_data = skip_q ? mem_dout[15:8] : mem_dout[7:0];
    assign w_npop     = {1'b0, pend_q} + {1'b0, w_req_v};
    assign w_avail    = count_q + c_CW'(w_n_in);

    // A pending underflow pop and a fresh req may both land on bytes arriving in this cycle.
    always_comb begin
        w_pops = (c_CW'(w_npop) <= w_avail) ? w_npop : w_avail[1:0];
        count_d  = w_avail - c_CW'(w_pops);
        rd_ptr_d = rd_ptr_q + c_AW'(w_pops);
        wr_ptr_d = wr_ptr_q + c_AW'(w_n_in);
        pend_d   = (w_npop != w_pops);
        skip_d   = w_ack_ok ? 1'b0 : skip_q;
        fetch_d  = w_ack_ok ? fetch_q + 31'd1 : fetch_q;
        armed_d  = armed_q;
        if (msu_data_seek) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            pend_d   = 1'b0;
            skip_d   = msu_data_addr[0];
            fetch_d  = msu_data_addr[31:1];
            armed_d  = 1'b1;
        end
    end

    assign w_space_ok = (count_d <= c_REFILL_MAX);

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_S_IDLE:  if (armed_d && w_space_ok) state_d = c_S_REQ;
            c_S_REQ: begin
                if (mem_ack)            state_d = w_space_ok ? c_S_REQ : c_S_IDLE;
                else if (msu_data_seek) state_d = c_S_STALE;
            end
            c_S_STALE: if (mem_ack) state_d = w_space_ok ? c_S_REQ : c_S_IDLE;
            default:   state_d = c_S_IDLE;
        endcase
    end

    // Forward freshly written bytes so the output is valid the cycle after the ack.
    always_comb begin
        w_rd_byte = buf_q[rd_ptr_d];
        if (w_ack_ok && (rd_ptr_d == wr_ptr_q))
            w_rd_byte = w_wr0_data;
        if (w_wr1_en && (rd_ptr_d == wr_ptr_q + c_AW'(1)))
            w_rd_byte = mem_dout[15:8];
    end

    assign data_d     = (count_d != '0) ? w_rd_byte : data_q;
    assign busy_d     = armed_d && (count_d == '0);
    assign mem_addr_d = (state_d == c_S_REQ) ? fetch_d : mem_addr_q;

    always_ff @(posedge CLK) begin
        if (w_ack_ok) begin
            buf_q[wr_ptr_q] <= w_wr0_data;
            if (w_wr1_en)
                buf_q[wr_ptr_q + c_AW'(1)] <= mem_dout[15:8];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= c_S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            fetch_q    <= '0;
            mem_addr_q <= '0;
            skip_q     <= 1'b0;
            armed_q    <= 1'b0;
            pend_q     <= 1'b0;
            busy_q     <= 1'b0;
            data_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            fetch_q    <= fetch_d;
            mem_addr_q <= mem_addr_d;
            skip_q     <= skip_d;
            armed_q    <= armed_d;
            pend_q     <= pend_d;
            busy_q     <= busy_d;
            data_q     <= data_d;
        end
    end

    assign mem_rd               = (state_q != c_S_IDLE);
    assign mem_addr             = mem_addr_q;
    assign msu_data_in          = data_q;
    assign msu_status_data_busy = busy_q;

endmodule
`default_nettype wire

// File: doc/msu_data_fetch.md
# msu_data_fetch

Prefetch engine for the MSU-1 data port. It sits between the MSU register block and the external memory that holds the `.msu` data file. It converts seek pulses and per-byte read pulses into 16-bit word fetches. A small byte ring buffer keeps `msu_data_in` valid for the next read, and `msu_status_data_busy` is raised while the byte at the current address is not yet available.

## Interface
- `DEPTH`, default 16: ring buffer size in bytes; power of two, minimum 4.
- `CLK` in 1: system clock; single clock domain.
- `RST_N` in 1: reset, asynchronous, active-low.
- `msu_data_addr` in 32: byte address; sampled only on `msu_data_seek`.
- `msu_data_seek` in 1: one-cycle pulse that flushes the buffer and restarts fetching at `msu_data_addr`.
- `msu_data_req` in 1: one-cycle pulse meaning the current byte was consumed; advance to the next byte.
- `msu_data_in` out 8: byte at the current read address.
- `msu_status_data_busy` out 1: current byte not yet valid.
- `mem_rd` out 1: word read request; level signal.
- `mem_addr` out 31: word address, equal to byte address [31:1].
- `mem_ack` in 1: one-cycle pulse; `mem_dout` is valid in this cycle.
- `mem_dout` in 16: fetched word. [7:0] is the even byte and [15:8] is the odd byte (little-endian).

## Operation
- **Storage:** byte ring buffer of `DEPTH` entries, with `wr_ptr`, `rd_ptr` and `count` (width log2(`DEPTH`)+1). `fetch_waddr` is the 31-bit word address of the next fetch and wraps from 0x7FFFFFFF to 0.
- **Data output:** `msu_data_in` = buffer[`rd_ptr`] whenever `count` ≥ 1. Otherwise it holds its last value.
- **Fetch FSM states:**
  - IDLE: `mem_rd`=0. Go to REQ when the block is armed and (`DEPTH` − `count`) ≥ 2.
  - REQ: `mem_rd`=1, `mem_addr`=`fetch_waddr`, both held stable until `mem_ack`. On `mem_ack`:
    - write the bytes into the buffer;
    - increment `fetch_waddr`;
    - go to IDLE, or stay in REQ if space for another word remains.
  - STALE: entered when a seek arrives while in REQ. Keep `mem_rd`=1 and `mem_addr` unchanged until `mem_ack`, then discard the word and go to REQ at the new address.
- **Seek:**
  - `count`←0, pointers←0, `fetch_waddr`←`msu_data_addr`[31:1], `skip`←`msu_data_addr`[0], armed←1, busy←1.
  - `skip` discards the low byte of the first word after the seek.
- **Fill:** on an accepted (non-stale) ack, write two bytes (one if `skip`, then clear `skip`).
- **Req (pop):**
  - If `count` ≥ 1: `rd_ptr`+1, `count`−1.
  - If `count`=0 (underflow): the pop is recorded as pending, busy←1, and it is applied to the first byte that arrives.
- **Busy:** `msu_status_data_busy` = armed & (effective `count` = 0), registered.
- **Simultaneous events:**
  - seek + req: the seek wins and the req is dropped.
  - seek + ack: the word is discarded.
  - ack + req: both apply; `count` changes by +2−1 (or +1−1 when `skip` is set).
- **Before the first seek:** armed=0, no fetches, req ignored, busy=0.
- **Reset values:**
  - `msu_data_in`=0x00, `msu_status_data_busy`=0, `mem_rd`=0, `mem_addr`=0.
  - FSM=IDLE, armed=0, buffer contents don't-care.
- **Reset mid-transfer:** `mem_rd` drops immediately. A late `mem_ack` after reset is ignored because the FSM is in IDLE.

## Timing
- **Seek at cycle T:**
  - busy=1 from T+1.
  - `mem_rd`=1 with the new `mem_addr` at T+1, or after the stale ack completes.
- **Ack at cycle A:**
  - buffer and `count` are updated at the A+1 edge.
  - `msu_data_in` is valid and busy=0 at A+1.
  - with space remaining, a new `mem_rd` address is presented at A+1. There are no idle cycles between back-to-back fetches.
- **Req at cycle P:** `msu_data_in` shows the next byte at P+1. Busy rises at P+1 if the buffer became empty.
- **Throughput:** one word per ack; steady-state latency is bounded by memory latency only.

## Test plan
- **Seek to even address:** reset, seek to 0x00000010, ack with 0xBBAA → `mem_addr`=0x00000008 at T+1; at A+1 `msu_data_in`=0xAA, busy=0; after one req it shows 0xBB.
- **Seek to odd address:** seek to 0x00000011, ack with 0xBBAA → first byte 0xBB, `count`=1; the next fetch uses `mem_addr`=0x00000009.
- **Fill and drain:** with `DEPTH`=16 and memory acking every cycle, `count` stops at 16 and `mem_rd` drops. Sixteen reqs return sequential bytes with no busy. Fetching resumes once `count` ≤ 14.
- **Seek during outstanding fetch:** seek to 0x100 while REQ at word 0x20 → `mem_addr` stays 0x20 until ack. That word is discarded, the next `mem_addr`=0x80, and busy stays 1 throughout.
- **Simultaneous events:**
  - ack + req in the same cycle with `count`=1 → `count`=2 at the next edge, with correct byte order.
  - seek + req in the same cycle → the req is dropped.
- **Wrap and reset:**
  - seek to 0xFFFFFFFE, two acks → second `mem_addr`=0.
  - assert `RST_N` low mid-REQ → `mem_rd`=0 and busy=0 asynchronously; a following ack is ignored.
